// File: rtl/strided_vector_memory.sv
// -----------------------------------------------------------------------------
// strided_vector_memory
//   Vector data memory holding DEPTH words of WORD_W bits. Each request moves one
//   LANES-element vector. Element i lives at (base + i*stride) mod DEPTH, and
//   each lane has its own enable bit. The block serves PORT_LANES elements per
//   beat, so one request takes LANES/PORT_LANES beats. After the last beat it
//   holds a single response until the consumer accepts it.
//
// Ports
//   clk, reset             rising-edge clock; asynchronous active-low reset
//   req_valid/req_ready    request handshake (one operation in flight)
//   req_write              1 = store, 0 = load
//   req_base, req_stride   element-0 address and element stride (mod DEPTH)
//   req_mask               per-lane enable
//   req_wdata              store data, lane i at [WORD_W*i +: WORD_W]
//   resp_valid/resp_ready  response handshake
//   resp_write             echo of req_write for the pending response
//   resp_rdata             load data (all zero for stores and masked-off lanes)
//   busy                   operation in progress (beats or response pending)
// -----------------------------------------------------------------------------
module strided_vector_memory #(
    parameter int WORD_W     = 32,
    parameter int LANES      = 16,
    parameter int DEPTH      = 512,
    parameter int PORT_LANES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [$clog2(DEPTH)-1:0]  req_base,
    input  logic [$clog2(DEPTH)-1:0]  req_stride,
    input  logic [LANES-1:0]          req_mask,
    input  logic [LANES*WORD_W-1:0]   req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_write,
    output logic [LANES*WORD_W-1:0]   resp_rdata,
    output logic                      busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NBEATS = LANES / PORT_LANES;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BEAT, S_RESP} state_t;

    state_t                          state_q, state_d;
    logic [BEAT_W-1:0]               beat_q, beat_d;
    logic                            write_q, write_d;
    logic [ADDR_W-1:0]               base_q, base_d;
    logic [ADDR_W-1:0]               stride_q, stride_d;
    logic [LANES-1:0]                mask_q, mask_d;
    logic [LANES-1:0][WORD_W-1:0]    wdata_q, wdata_d;
    logic [LANES-1:0][WORD_W-1:0]    rdata_q, rdata_d;
    logic                            req_ready_q, req_ready_d;
    logic                            resp_valid_q, resp_valid_d;
    logic                            busy_q, busy_d;

    logic [WORD_W-1:0]               mem [DEPTH];

    // Lanes and addresses served by the current beat.
    logic [PORT_LANES-1:0][LANE_W-1:0] lane_idx;
    logic [PORT_LANES-1:0][ADDR_W-1:0] lane_addr;

    always_comb begin
        for (int j = 0; j < PORT_LANES; j++) begin
            lane_idx[j]  = LANE_W'(beat_q) * LANE_W'(PORT_LANES) + LANE_W'(j);
            // Truncation to ADDR_W is the mod-DEPTH wrap (DEPTH is a power of two).
            lane_addr[j] = base_q + ADDR_W'(lane_idx[j]) * stride_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        write_d      = write_q;
        base_d       = base_q;
        stride_d     = stride_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    base_d      = req_base;
                    stride_d    = req_stride;
                    mask_d      = req_mask;
                    wdata_d     = req_wdata;
                    rdata_d     = '0;
                    beat_d      = '0;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_BEAT;
                end
            end
            S_BEAT: begin
                // Loads never write memory, so a load only sees the memory
                // contents from before the request.
                for (int j = 0; j < PORT_LANES; j++) begin
                    rdata_d[lane_idx[j]] = (!write_q && mask_q[lane_idx[j]])
                                         ? mem[lane_addr[j]] : '0;
                end
                if (beat_q == BEAT_W'(NBEATS - 1)) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            write_q      <= 1'b0;
            base_q       <= '0;
            stride_q     <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            write_q      <= write_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    // The memory is not reset. A reset forces state_q to IDLE at once, which
    // stops any further store beats. The lanes are visited in ascending order,
    // so on an address collision the last write is from the highest lane, and
    // that lane wins.
    always_ff @(posedge clk) begin
        if (state_q == S_BEAT && write_q) begin
            for (int j = 0; j < PORT_LANES; j++) begin
                if (mask_q[lane_idx[j]]) begin
                    mem[lane_addr[j]] <= wdata_q[lane_idx[j]];
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_write = write_q;
    assign resp_rdata = rdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_strided_vector_memory.sv
// -----------------------------------------------------------------------------
// tb_strided_vector_memory
//   Directed bench for strided_vector_memory. A word-array model tracks memory
//   contents and predicts handshakes, latency and response data. A negedge
//   process compares the DUT against that model every cycle. The driver also
//   checks hand-computed literal vectors.
// -----------------------------------------------------------------------------
module tb_strided_vector_memory;

    localparam int WORD_W     = 32;
    localparam int LANES      = 16;
    localparam int DEPTH      = 512;
    localparam int PORT_LANES = 4;
    localparam int ADDR_W     = 9;
    localparam int NBEATS     = LANES / PORT_LANES;
    localparam int VW         = LANES * WORD_W;

    typedef logic [LANES-1:0][WORD_W-1:0] vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_base = '0;
    logic [ADDR_W-1:0] req_stride = '0;
    logic [LANES-1:0]  req_mask = '0;
    logic [VW-1:0]     req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic              resp_write;
    logic [VW-1:0]     resp_rdata;
    logic              busy;

    int total = 0;
    int bad   = 0;

    strided_vector_memory #(
        .WORD_W(WORD_W), .LANES(LANES), .DEPTH(DEPTH), .PORT_LANES(PORT_LANES)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_base(req_base), .req_stride(req_stride), .req_mask(req_mask),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WORD_W-1:0] model_mem [DEPTH];

    function automatic int eaddr(int b, int s, int i);
        return (b + i * s) % DEPTH;
    endfunction

    function automatic vec_t model_load(int b, int s, logic [LANES-1:0] m);
        vec_t r = '0;
        for (int i = 0; i < LANES; i++)
            if (m[i]) r[i] = model_mem[eaddr(b, s, i)];
        return r;
    endfunction

    // Applies lanes lo..hi in ascending order: the later (higher) lane wins.
    function automatic void model_store(int b, int s, logic [LANES-1:0] m, vec_t d, int lo, int hi);
        for (int i = lo; i <= hi; i++)
            if (m[i]) model_mem[eaddr(b, s, i)] = d[i];
    endfunction

    function automatic vec_t mkvec(int start, int inc);
        vec_t r;
        for (int i = 0; i < LANES; i++) r[i] = WORD_W'(start + i * inc);
        return r;
    endfunction

    // ---------------- per-cycle compare process ----------------
    logic              pending = 1'b0;
    int                since   = 0;
    logic              exp_w;
    int                exp_b, exp_s;
    logic [LANES-1:0]  exp_m;
    vec_t              exp_d, exp_r;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_req_ready",  VW'(req_ready),  VW'(1));
            chk("rst_resp_valid", VW'(resp_valid), VW'(0));
            chk("rst_busy",       VW'(busy),       VW'(0));
            chk("rst_resp_write", VW'(resp_write), VW'(0));
            chk("rst_resp_rdata", resp_rdata,      '0);
            pending = 1'b0;
        end else begin
            if (pending) since++;
            chk("cyc_req_ready",  VW'(req_ready),  VW'(!pending));
            chk("cyc_busy",       VW'(busy),       VW'(pending));
            chk("cyc_resp_valid", VW'(resp_valid), VW'(pending && since >= NBEATS + 1));
            if (resp_valid) begin
                chk("cyc_resp_write", VW'(resp_write), VW'(exp_w));
                chk("cyc_resp_rdata", resp_rdata, exp_r);
            end
            if (pending && resp_valid && resp_ready) begin
                if (exp_w) model_store(exp_b, exp_s, exp_m, exp_d, 0, LANES - 1);
                pending = 1'b0;
            end else if (!pending && req_valid && req_ready) begin
                exp_w = req_write;
                exp_b = int'(req_base);
                exp_s = int'(req_stride);
                exp_m = req_mask;
                exp_d = req_wdata;
                exp_r = req_write ? '0 : model_load(exp_b, exp_s, exp_m);
                pending = 1'b1;
                since = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns just after the accepting edge. Request inputs are then scrambled
    // because the block samples them only at acceptance.
    task automatic issue(input logic w, input int b, input int s,
                         input logic [LANES-1:0] m, input vec_t d);
        int n = 0;
        req_valid = 1'b1; req_write = w;
        req_base = ADDR_W'(b); req_stride = ADDR_W'(s);
        req_mask = m; req_wdata = d;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("accept_timeout", VW'(0), VW'(1));
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w;
        req_base = ADDR_W'($urandom); req_stride = ADDR_W'($urandom);
        req_mask = ~m; req_wdata = ~d;
    endtask

    task automatic wait_resp(input string nm);
        int lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk(nm, VW'(lat), VW'(NBEATS));
    endtask

    task automatic finish_resp(output vec_t r);
        r = resp_rdata;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic do_op(input string nm, input logic w, input int b, input int s,
                         input logic [LANES-1:0] m, input vec_t d, output vec_t r);
        issue(w, b, s, m, d);
        wait_resp(nm);
        finish_resp(r);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        vec_t r, r0, e;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // 1: unit-stride store then load; lanes hold 1..16
        do_op("t1_st_lat", 1, 0, 1, 16'hFFFF, mkvec(1, 1), r);
        chk("t1_st_rdata", r, '0);
        do_op("t1_ld_lat", 0, 0, 1, 16'hFFFF, '0, r);
        chk("t1_ld", r, mkvec(1, 1));

        // 2: wrap-around from word 510
        do_op("t2_st_lat", 1, 510, 1, 16'hFFFF, mkvec(32'hA000, 1), r);
        do_op("t2_ld_lat", 0, 510, 1, 16'hFFFF, '0, r);
        chk("t2_ld", r, mkvec(32'hA000, 1));

        // pattern mem[k] = k for k = 0..63
        for (int k = 0; k < 4; k++)
            do_op("pat_lat", 1, 16 * k, 1, 16'hFFFF, mkvec(16 * k, 1), r);

        // 4: stride 4, upper half masked off
        do_op("t4_lat", 0, 0, 4, 16'h00FF, '0, r);
        e = '0;
        for (int i = 0; i < 8; i++) e[i] = WORD_W'(4 * i);
        chk("t4_ld", r, e);

        // mask = 0 load: zeros, full latency
        do_op("m0_lat", 0, 5, 1, 16'h0000, '0, r);
        chk("m0_ld", r, '0);

        // sparse-mask store and load with stride 3, and a wide stride that wraps
        do_op("sp_st_lat", 1, 100, 3, 16'hA5C3, mkvec(32'h5000, 7), r);
        do_op("sp_ld_lat", 0, 100, 3, 16'hA5C3, '0, r);
        e = '0;
        for (int i = 0; i < LANES; i++) if (16'hA5C3 & (1 << i)) e[i] = WORD_W'(32'h5000 + 7 * i);
        chk("sp_ld", r, e);
        do_op("ws_st_lat", 1, 400, 200, 16'hFFFF, mkvec(32'h7700, 1), r);
        do_op("ws_ld_lat", 0, 400, 200, 16'hFFFF, '0, r);
        chk("ws_ld", r, mkvec(32'h7700, 1));

        // 5: stall the response, with a competing request during the stall
        issue(0, 0, 1, 16'hFFFF, '0);
        wait_resp("t5a_lat");
        r0 = resp_rdata;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin
                req_valid = 1'b1; req_write = 1'b0; req_base = 9'd16;
                req_stride = 9'd1; req_mask = 16'hFFFF;
            end
            chk("t5_hold_rdata", resp_rdata, r0);
            chk("t5_hold_valid", VW'(resp_valid), VW'(1));
            chk("t5_hold_ready", VW'(req_ready), VW'(0));
            @(posedge clk); #1;
        end
        finish_resp(r);
        chk("t5_a", r, mkvec(0, 1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp("t5b_lat");
        finish_resp(r);
        chk("t5_b", r, mkvec(16, 1));

        // 6: reset after the second beat of a store to words 40..55
        issue(1, 40, 1, 16'hFFFF, mkvec(32'hB000, 1));
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_req_ready",  VW'(req_ready),  VW'(1));
        chk("t6_rst_resp_valid", VW'(resp_valid), VW'(0));
        chk("t6_rst_busy",       VW'(busy),       VW'(0));
        model_store(40, 1, 16'hFFFF, mkvec(32'hB000, 1), 0, 7);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_op("t6_ld_lat", 0, 40, 1, 16'hFFFF, '0, r);
        for (int i = 0; i < LANES; i++) e[i] = (i < 8) ? WORD_W'(32'hB000 + i) : WORD_W'(40 + i);
        chk("t6_ld", r, e);

        // 3: stride 0 collision; the highest lane (15) wins
        do_op("t3_st_lat", 1, 8, 0, 16'hFFFF, mkvec(0, 1), r);
        do_op("t3_ld_lat", 0, 8, 0, 16'hFFFF, '0, r);
        chk("t3_ld", r, mkvec(15, 0));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
